// File: rtl/pc_select_pkg.sv
// pc_select_pkg: Y86-64 icodes, status codes and fetch FSM states
package pc_select_pkg;
  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ = 4'h6;
  localparam logic [3:0] IJXX = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET = 4'h9;
  localparam logic [3:0] IPUSHQ = 4'hA;
  localparam logic [3:0] IPOPQ = 4'hB;
  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;
  typedef enum logic [1:0] {RUN = 2'd0, RET_WAIT = 2'd1, HALT = 2'd2} state_e;
  function automatic logic is_halt_stat(input logic [2:0] s);
    return s == SHLT || s == SADR || s == SINS;
  endfunction
endpackage

// File: rtl/pc_select_if.sv
// pc_select_if: pipeline-side signals feeding and leaving the fetch PC selector
interface pc_select_if #(parameter int CNT_W = 32);
  logic stall_i;
  logic [3:0] f_icode_i;
  logic [63:0] f_valC_i;
  logic [63:0] f_valP_i;
  logic [3:0] M_icode_i;
  logic M_cnd_i;
  logic [63:0] M_valA_i;
  logic [3:0] W_icode_i;
  logic [63:0] W_valM_i;
  logic [2:0] W_stat_i;
  logic [63:0] pc_o;
  logic [63:0] pred_pc_o;
  logic fetch_valid_o;
  logic [1:0] state_o;
  logic [CNT_W-1:0] fetch_cnt_o;
  modport master (
    output stall_i, f_icode_i, f_valC_i, f_valP_i, M_icode_i, M_cnd_i, M_valA_i,
           W_icode_i, W_valM_i, W_stat_i,
    input pc_o, pred_pc_o, fetch_valid_o, state_o, fetch_cnt_o
  );
  modport slave (
    input stall_i, f_icode_i, f_valC_i, f_valP_i, M_icode_i, M_cnd_i, M_valA_i,
          W_icode_i, W_valM_i, W_stat_i,
    output pc_o, pred_pc_o, fetch_valid_o, state_o, fetch_cnt_o
  );
endinterface

// File: rtl/pc_select_predict.sv
// pc_select_predict: next-PC prediction, jumps and calls predicted taken
module pc_select_predict
  import pc_select_pkg::*;
(
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  output logic [63:0] pred_pc
);
  assign pred_pc = (f_icode == IJXX || f_icode == ICALL) ? f_valC : f_valP;
endmodule

// File: rtl/pc_select.sv
// pc_select: fetch PC selection, ret/halt fetch FSM and fetch counter
module pc_select
  import pc_select_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int CNT_W = 32
) (
  input logic clk_i,
  input logic rst_i,
  pc_select_if.slave bus
);
  state_e state_q, state_d;
  logic [63:0] pred_pc_q, pred_pc_d, next_pc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mispredict, ret_w, redirect, fetch_valid, adv;
  pc_select_predict u_predict (
    .f_icode(bus.f_icode_i),
    .f_valC(bus.f_valC_i),
    .f_valP(bus.f_valP_i),
    .pred_pc(next_pc)
  );
  // redirect selection, fetch gating and next-state computation
  always_comb begin
    mispredict = bus.M_icode_i == IJXX && !bus.M_cnd_i;
    ret_w = bus.W_icode_i == IRET;
    redirect = mispredict || ret_w;
    fetch_valid = state_q == RUN || (state_q == RET_WAIT && redirect);
    adv = fetch_valid && !bus.stall_i;
    pred_pc_d = adv ? next_pc : pred_pc_q;
    cnt_d = (adv && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    state_d = is_halt_stat(bus.W_stat_i) ? HALT :
              bus.stall_i ? state_q :
              (state_q == RUN && bus.f_icode_i == IRET && !redirect) ? RET_WAIT :
              (state_q == RET_WAIT && redirect) ? RUN : state_q;
  end
  // state registers, reset overrides every state including HALT
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pred_pc_q <= RESET_PC;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pred_pc_q <= pred_pc_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.pc_o = mispredict ? bus.M_valA_i : ret_w ? bus.W_valM_i : pred_pc_q;
  assign bus.fetch_valid_o = fetch_valid;
  assign bus.pred_pc_o = pred_pc_q;
  assign bus.state_o = state_q;
  assign bus.fetch_cnt_o = cnt_q;
endmodule

// File: tb/tb_pc_select.sv
// tb_pc_select: scenario-driven scoreboard bench for pc_select
module tb_pc_select;
  typedef struct {
    string name;
    logic [63:0] pc;
    logic v;
    logic [1:0] st;
    logic [31:0] cnt;
    logic [63:0] pred;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t e;
  pc_select_if #(.CNT_W(32)) bus ();
  pc_select #(.RESET_PC(64'd0), .CNT_W(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle_in();
    bus.stall_i = 0;
    bus.f_icode_i = 4'h1;
    bus.f_valC_i = 64'h0;
    bus.f_valP_i = 64'h0;
    bus.M_icode_i = 4'h1;
    bus.M_cnd_i = 1;
    bus.M_valA_i = 64'h0;
    bus.W_icode_i = 4'h1;
    bus.W_valM_i = 64'h0;
    bus.W_stat_i = 3'd1;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
    bus.f_icode_i = ic;
    bus.f_valC_i = vc;
    bus.f_valP_i = vp;
  endtask

  task automatic push(input string n, input logic [63:0] pc, input logic v, input logic [1:0] st,
                      input logic [31:0] cnt, input logic [63:0] pred);
    exp_t x;
    x.name = n; x.pc = pc; x.v = v; x.st = st; x.cnt = cnt; x.pred = pred;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 2; i++) begin
      fetch(4'h6, 64'h0, i == 0 ? 64'h2 : 64'h4);
      push(i == 0 ? "reset_first" : "seq_second", i == 0 ? 64'h0 : 64'h2, 1, 0, i, i == 0 ? 64'h0 : 64'h2);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o} !== {e.pc, e.v, e.st, e.cnt, e.pred}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b st=%0d cnt=%0d pred=%h, required pc=%h v=%b st=%0d cnt=%0d pred=%h",
                 e.name, bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o, e.pc, e.v, e.st, e.cnt, e.pred);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_call();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) fetch(4'h8, 64'h100, 64'hD); else fetch(4'h6, 64'h0, 64'h102);
      push(i == 0 ? "call_fetch" : "call_target", i == 0 ? 64'h4 : 64'h100, 1, 0, 2 + i, i == 0 ? 64'h4 : 64'h100);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o} !== {e.pc, e.v, e.st, e.cnt, e.pred}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b st=%0d cnt=%0d pred=%h, required pc=%h v=%b st=%0d cnt=%0d pred=%h",
                 e.name, bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o, e.pc, e.v, e.st, e.cnt, e.pred);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 5; i++) begin
      bus.M_icode_i = 4'h1; bus.M_cnd_i = 1; bus.M_valA_i = 64'h0;
      case (i)
        0: begin fetch(4'h7, 64'h40, 64'h10B); push("jxx_fetch", 64'h102, 1, 0, 4, 64'h102); end
        1: begin fetch(4'h6, 64'h0, 64'h42); push("jxx_predicted", 64'h40, 1, 0, 5, 64'h40); end
        2: begin
          bus.M_icode_i = 4'h7; bus.M_cnd_i = 0; bus.M_valA_i = 64'h1A;
          fetch(4'h6, 64'h0, 64'h1C); push("mispredict_redirect", 64'h1A, 1, 0, 6, 64'h42);
        end
        3: begin fetch(4'h6, 64'h0, 64'h1E); push("mispredict_resume", 64'h1C, 1, 0, 7, 64'h1C); end
        default: begin
          bus.M_icode_i = 4'h7; bus.M_cnd_i = 1; bus.M_valA_i = 64'h99;
          fetch(4'h6, 64'h0, 64'h20); push("taken_no_redirect", 64'h1E, 1, 0, 8, 64'h1E);
        end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o} !== {e.pc, e.v, e.st, e.cnt, e.pred}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b st=%0d cnt=%0d pred=%h, required pc=%h v=%b st=%0d cnt=%0d pred=%h",
                 e.name, bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o, e.pc, e.v, e.st, e.cnt, e.pred);
      end
      @(posedge clk); #1;
    end
    bus.M_icode_i = 4'h1; bus.M_cnd_i = 1;
  endtask

  task automatic test_ret();
    for (int i = 0; i < 6; i++) begin
      bus.W_icode_i = 4'h1; bus.W_valM_i = 64'h0; bus.W_stat_i = 3'd1;
      if (i == 0) begin
        fetch(4'h9, 64'h0, 64'h21); push("ret_fetch", 64'h20, 1, 0, 9, 64'h20);
      end else if (i < 4) begin
        bus.W_stat_i = 3'd0;
        fetch(4'h6, 64'h0, 64'h777); push("ret_bubble", 64'h21, 0, 1, 10, 64'h21);
      end else if (i == 4) begin
        bus.W_icode_i = 4'h9; bus.W_valM_i = 64'h58;
        fetch(4'h6, 64'h0, 64'h5A); push("ret_resolve", 64'h58, 1, 1, 10, 64'h21);
      end else begin
        fetch(4'h6, 64'h0, 64'h5C); push("ret_resume", 64'h5A, 1, 0, 11, 64'h5A);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o} !== {e.pc, e.v, e.st, e.cnt, e.pred}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b st=%0d cnt=%0d pred=%h, required pc=%h v=%b st=%0d cnt=%0d pred=%h",
                 e.name, bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o, e.pc, e.v, e.st, e.cnt, e.pred);
      end
      @(posedge clk); #1;
    end
    bus.W_icode_i = 4'h1; bus.W_stat_i = 3'd1;
  endtask

  task automatic test_priority();
    for (int i = 0; i < 4; i++) begin
      bus.M_icode_i = 4'h1; bus.M_cnd_i = 1; bus.W_icode_i = 4'h1;
      case (i)
        0: begin fetch(4'h9, 64'h0, 64'h5D); push("prio_ret_fetch", 64'h5C, 1, 0, 12, 64'h5C); end
        1: begin fetch(4'h6, 64'h0, 64'h5F); push("prio_bubble", 64'h5D, 0, 1, 13, 64'h5D); end
        2: begin
          bus.M_icode_i = 4'h7; bus.M_cnd_i = 0; bus.M_valA_i = 64'h30;
          bus.W_icode_i = 4'h9; bus.W_valM_i = 64'h80;
          fetch(4'h6, 64'h0, 64'h32); push("prio_m_wins", 64'h30, 1, 1, 13, 64'h5D);
        end
        default: begin fetch(4'h6, 64'h0, 64'h34); push("prio_resume", 64'h32, 1, 0, 14, 64'h32); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o} !== {e.pc, e.v, e.st, e.cnt, e.pred}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b st=%0d cnt=%0d pred=%h, required pc=%h v=%b st=%0d cnt=%0d pred=%h",
                 e.name, bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o, e.pc, e.v, e.st, e.cnt, e.pred);
      end
      @(posedge clk); #1;
    end
    bus.M_icode_i = 4'h1; bus.M_cnd_i = 1; bus.W_icode_i = 4'h1;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      bus.stall_i = i < 3;
      fetch(4'h8, 64'h999, i < 3 ? 64'h998 : 64'h36);
      if (i == 3) fetch(4'h6, 64'h0, 64'h36);
      push(i < 3 ? "stall_hold" : "stall_release", 64'h34, 1, 0, 15, 64'h34);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o} !== {e.pc, e.v, e.st, e.cnt, e.pred}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b st=%0d cnt=%0d pred=%h, required pc=%h v=%b st=%0d cnt=%0d pred=%h",
                 e.name, bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o, e.pc, e.v, e.st, e.cnt, e.pred);
      end
      @(posedge clk); #1;
    end
    bus.stall_i = 0;
  endtask

  task automatic test_halt();
    for (int i = 0; i < 12; i++) begin
      bus.W_stat_i = i == 0 ? 3'd2 : 3'd1;
      rst = i == 11;
      if (i == 0) begin
        fetch(4'h6, 64'h0, 64'h38); push("halt_trigger", 64'h36, 1, 0, 16, 64'h36);
      end else begin
        fetch(4'h8, 64'hABC, 64'hABD); push(i == 11 ? "halt_before_reset" : "halt_frozen", 64'h38, 0, 2, 17, 64'h38);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o} !== {e.pc, e.v, e.st, e.cnt, e.pred}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b st=%0d cnt=%0d pred=%h, required pc=%h v=%b st=%0d cnt=%0d pred=%h",
                 e.name, bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o, e.pc, e.v, e.st, e.cnt, e.pred);
      end
      @(posedge clk); #1;
    end
    rst = 0;
    fetch(4'h6, 64'h0, 64'h2);
    push("halt_reset_exit", 64'h0, 1, 0, 0, 64'h0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o} !== {e.pc, e.v, e.st, e.cnt, e.pred}) begin
      errors++;
      $display("FAIL %s: got pc=%h v=%b st=%0d cnt=%0d pred=%h, required pc=%h v=%b st=%0d cnt=%0d pred=%h",
               e.name, bus.pc_o, bus.fetch_valid_o, bus.state_o, bus.fetch_cnt_o, bus.pred_pc_o, e.pc, e.v, e.st, e.cnt, e.pred);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_call();
    test_mispredict();
    test_ret();
    test_priority();
    test_stall();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
